// File: rtl/sensor_status.sv
// Vehicle sensor status: filtered thermal FSM with hysteresis, fuel-empty flag and trip odometer.
// Define SENSOR_STATUS_OVERHEAT_LATCH_EN to make cpu_overheated sticky until reset once HOT is reached.
module sensor_status #(
    parameter logic [7:0] HOT_TH  = 8'd90,
    parameter logic [7:0] COOL_TH = 8'd80,
    parameter int         FILT_N  = 3,
    parameter logic [7:0] FUEL_TH = 8'd10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        temp_valid,
    input  logic [7:0]  temp_data,
    input  logic        fuel_valid,
    input  logic [7:0]  fuel_level,
    input  logic        trip_start,
    input  logic [15:0] dest_dist,
    input  logic        odo_pulse,
    output logic        cpu_overheated,
    output logic        gas_tank_empty,
    output logic        arrived,
    output logic [15:0] trip_dist
);

    localparam logic [3:0] FILT_CNT = 4'(FILT_N);

    typedef enum logic [1:0] {T_COOL, T_WARMING, T_HOT, T_COOLING} therm_t;
    typedef enum logic [1:0] {TR_IDLE, TR_DRIVING, TR_ARRIVED} trip_t;

    therm_t      t_state, t_next;
    logic [3:0]  run_cnt, run_next;
    logic [3:0]  run_inc;
    logic        is_hot, is_cool;

    trip_t       tr_state, tr_next;
    logic [15:0] target, target_next;
    logic [15:0] dist_next, dist_inc;

    assign is_hot   = (temp_data >= HOT_TH);
    assign is_cool  = (temp_data < COOL_TH);
    assign run_inc  = run_cnt + 4'd1;
    assign dist_inc = (trip_dist == 16'hFFFF) ? trip_dist : trip_dist + 16'd1;

    always_comb begin
        t_next   = t_state;
        run_next = run_cnt;
        if (temp_valid) begin
            unique case (t_state)
                T_COOL: begin
                    if (is_hot) begin
                        if (FILT_CNT == 4'd1) begin
                            t_next   = T_HOT;
                            run_next = 4'd0;
                        end else begin
                            t_next   = T_WARMING;
                            run_next = 4'd1;
                        end
                    end
                end
                T_WARMING: begin
                    if (is_hot) begin
                        if (run_inc >= FILT_CNT) begin
                            t_next   = T_HOT;
                            run_next = 4'd0;
                        end else begin
                            run_next = run_inc;
                        end
                    end else begin
                        t_next   = T_COOL;
                        run_next = 4'd0;
                    end
                end
                T_HOT: begin
`ifdef SENSOR_STATUS_OVERHEAT_LATCH_EN
                    // Sticky overheat: cool samples are ignored once HOT is reached.
                    t_next   = T_HOT;
`else
                    if (is_cool) begin
                        if (FILT_CNT == 4'd1) begin
                            t_next   = T_COOL;
                            run_next = 4'd0;
                        end else begin
                            t_next   = T_COOLING;
                            run_next = 4'd1;
                        end
                    end
`endif
                end
                T_COOLING: begin
                    if (is_cool) begin
                        if (run_inc >= FILT_CNT) begin
                            t_next   = T_COOL;
                            run_next = 4'd0;
                        end else begin
                            run_next = run_inc;
                        end
                    end else begin
                        t_next   = T_HOT;
                        run_next = 4'd0;
                    end
                end
                default: begin
                    t_next   = T_COOL;
                    run_next = 4'd0;
                end
            endcase
        end
    end

    // trip_start has priority over everything, including a same-cycle odo_pulse.
    always_comb begin
        tr_next     = tr_state;
        target_next = target;
        dist_next   = trip_dist;
        if (trip_start) begin
            tr_next     = TR_DRIVING;
            target_next = dest_dist;
            dist_next   = 16'd0;
        end else begin
            unique case (tr_state)
                TR_IDLE: dist_next = 16'd0;
                TR_DRIVING: begin
                    if (odo_pulse) dist_next = dist_inc;
                    if (trip_dist >= target) tr_next = TR_ARRIVED;
                end
                TR_ARRIVED: begin
                    if (odo_pulse) dist_next = dist_inc;
                end
                default: begin
                    tr_next   = TR_IDLE;
                    dist_next = 16'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t_state        <= T_COOL;
            run_cnt        <= 4'd0;
            tr_state       <= TR_IDLE;
            target         <= 16'd0;
            trip_dist      <= 16'd0;
            cpu_overheated <= 1'b0;
            gas_tank_empty <= 1'b0;
            arrived        <= 1'b0;
        end else begin
            t_state        <= t_next;
            run_cnt        <= run_next;
            tr_state       <= tr_next;
            target         <= target_next;
            trip_dist      <= dist_next;
            cpu_overheated <= (t_next == T_HOT) || (t_next == T_COOLING);
            arrived        <= (tr_next == TR_ARRIVED);
            if (fuel_valid) gas_tank_empty <= (fuel_level <= FUEL_TH);
        end
    end

endmodule

// File: tb/tb_sensor_status.sv
// Bench for sensor_status: fixed vector table, directed trip/reset sequences, randomized run vs. reference model.
module tb_sensor_status;

    localparam int HOT  = 90;
    localparam int COOL = 80;
    localparam int FILT = 3;
    localparam int FUEL = 10;
`ifdef SENSOR_STATUS_OVERHEAT_LATCH_EN
    localparam logic LATCH = 1'b1;
`else
    localparam logic LATCH = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        temp_valid, fuel_valid, trip_start, odo_pulse;
    logic [7:0]  temp_data, fuel_level;
    logic [15:0] dest_dist;
    logic        cpu_overheated, gas_tank_empty, arrived;
    logic [15:0] trip_dist;

    int total = 0;
    int bad   = 0;

    sensor_status #(.HOT_TH(8'd90), .COOL_TH(8'd80), .FILT_N(3), .FUEL_TH(8'd10)) dut (
        .clk(clk), .rst_n(rst_n),
        .temp_valid(temp_valid), .temp_data(temp_data),
        .fuel_valid(fuel_valid), .fuel_level(fuel_level),
        .trip_start(trip_start), .dest_dist(dest_dist), .odo_pulse(odo_pulse),
        .cpu_overheated(cpu_overheated), .gas_tank_empty(gas_tank_empty),
        .arrived(arrived), .trip_dist(trip_dist)
    );

    always #5 clk = ~clk;

    // Reference model: overheat flag plus a run length of qualifying samples.
    bit m_over, m_empty;
    int m_run, m_mode, m_dist, m_tgt;   // m_mode: 0 idle, 1 driving, 2 arrived

    task automatic model_reset();
        m_over = 0; m_empty = 0; m_run = 0;
        m_mode = 0; m_dist = 0; m_tgt = 0;
    endtask

    task automatic model_step();
        bit reach;
        if (temp_valid) begin
            if (!m_over) begin
                if (int'(temp_data) >= HOT) m_run++; else m_run = 0;
                if (m_run >= FILT) begin m_over = 1; m_run = 0; end
            end else if (!LATCH) begin
                if (int'(temp_data) < COOL) m_run++; else m_run = 0;
                if (m_run >= FILT) begin m_over = 0; m_run = 0; end
            end
        end
        if (fuel_valid) m_empty = (int'(fuel_level) <= FUEL);
        if (trip_start) begin
            m_tgt = int'(dest_dist); m_dist = 0; m_mode = 1;
        end else if (m_mode == 1) begin
            reach = (m_dist >= m_tgt);
            if (odo_pulse && m_dist < 65535) m_dist++;
            if (reach) m_mode = 2;
        end else if (m_mode == 2) begin
            if (odo_pulse && m_dist < 65535) m_dist++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".over"},  32'(cpu_overheated), 32'(m_over));
        chk({tag, ".empty"}, 32'(gas_tank_empty), 32'(m_empty));
        chk({tag, ".arr"},   32'(arrived),        32'(m_mode == 2));
        chk({tag, ".dist"},  32'(trip_dist),      32'(m_dist));
    endtask

    task automatic idle_inputs();
        temp_valid = 0; temp_data = 0; fuel_valid = 0; fuel_level = 0;
        trip_start = 0; dest_dist = 0; odo_pulse = 0;
    endtask

    task automatic do_reset();
        rst_n = 0;
        model_reset();
        tick();
        rst_n = 1;
    endtask

    typedef struct {
        logic       tv;
        logic [7:0] td;
        logic       fv;
        logic [7:0] fl;
        logic       eo;
        logic       ee;
    } vec_t;

    vec_t tbl[19];

    initial begin
        tbl[0]  = '{1'b1, 8'd95,  1'b1, 8'd10,  1'b0,  1'b1};
        tbl[1]  = '{1'b1, 8'd95,  1'b0, 8'd0,   1'b0,  1'b1};
        tbl[2]  = '{1'b1, 8'd70,  1'b0, 8'd0,   1'b0,  1'b1};
        tbl[3]  = '{1'b1, 8'd95,  1'b1, 8'd11,  1'b0,  1'b0};
        tbl[4]  = '{1'b1, 8'd95,  1'b0, 8'd0,   1'b0,  1'b0};
        tbl[5]  = '{1'b0, 8'd30,  1'b0, 8'd0,   1'b0,  1'b0};
        tbl[6]  = '{1'b1, 8'd95,  1'b0, 8'd0,   1'b1,  1'b0};
        tbl[7]  = '{1'b1, 8'd85,  1'b0, 8'd0,   1'b1,  1'b0};
        tbl[8]  = '{1'b1, 8'd85,  1'b0, 8'd0,   1'b1,  1'b0};
        tbl[9]  = '{1'b1, 8'd85,  1'b0, 8'd0,   1'b1,  1'b0};
        tbl[10] = '{1'b1, 8'd79,  1'b0, 8'd0,   1'b1,  1'b0};
        tbl[11] = '{1'b1, 8'd79,  1'b0, 8'd0,   1'b1,  1'b0};
        tbl[12] = '{1'b1, 8'd85,  1'b0, 8'd0,   1'b1,  1'b0};
        tbl[13] = '{1'b1, 8'd79,  1'b0, 8'd0,   1'b1,  1'b0};
        tbl[14] = '{1'b1, 8'd79,  1'b0, 8'd0,   1'b1,  1'b0};
        tbl[15] = '{1'b0, 8'd0,   1'b0, 8'd0,   1'b1,  1'b0};
        tbl[16] = '{1'b1, 8'd79,  1'b0, 8'd0,   LATCH, 1'b0};
        tbl[17] = '{1'b1, 8'd95,  1'b1, 8'd255, LATCH, 1'b0};
        tbl[18] = '{1'b1, 8'd0,   1'b1, 8'd0,   LATCH, 1'b1};

        idle_inputs();
        rst_n = 0;
        model_reset();
        #12;
        chk("reset.over",  32'(cpu_overheated), 32'd0);
        chk("reset.empty", 32'(gas_tank_empty), 32'd0);
        chk("reset.arr",   32'(arrived),        32'd0);
        chk("reset.dist",  32'(trip_dist),      32'd0);
        @(posedge clk); #1;
        rst_n = 1;

        for (int i = 0; i < 19; i++) begin
            temp_valid = tbl[i].tv; temp_data  = tbl[i].td;
            fuel_valid = tbl[i].fv; fuel_level = tbl[i].fl;
            tick();
            chk($sformatf("vec%0d.over", i),  32'(cpu_overheated), 32'(tbl[i].eo));
            chk($sformatf("vec%0d.empty", i), 32'(gas_tank_empty), 32'(tbl[i].ee));
        end
        idle_inputs();

        // Trip to 5 ticks: arrival one cycle after the fifth pulse.
        do_reset();
        trip_start = 1; dest_dist = 16'd5; tick();
        trip_start = 0; odo_pulse = 1;
        for (int i = 0; i < 5; i++) tick();
        odo_pulse = 0;
        chk("trip5.dist", 32'(trip_dist), 32'd5);
        chk("trip5.pre_arr", 32'(arrived), 32'd0);
        tick();
        chk("trip5.arr", 32'(arrived), 32'd1);
        odo_pulse = 1; tick(); odo_pulse = 0;
        chk("trip5.after_arr_dist", 32'(trip_dist), 32'd6);
        chk("trip5.after_arr_arr", 32'(arrived), 32'd1);

        // Zero target: arrived two cycles after the trip_start cycle.
        trip_start = 1; dest_dist = 16'd0; tick(); trip_start = 0;
        chk("trip0.c1_arr", 32'(arrived), 32'd0);
        chk("trip0.c1_dist", 32'(trip_dist), 32'd0);
        tick();
        chk("trip0.c2_arr", 32'(arrived), 32'd1);

        // Asynchronous reset mid-trip.
        trip_start = 1; dest_dist = 16'd10; tick(); trip_start = 0;
        odo_pulse = 1;
        for (int i = 0; i < 3; i++) tick();
        chk("midrst.pre_dist", 32'(trip_dist), 32'd3);
        rst_n = 0;
        #1;
        model_reset();
        chk("midrst.dist",  32'(trip_dist),      32'd0);
        chk("midrst.arr",   32'(arrived),        32'd0);
        chk("midrst.over",  32'(cpu_overheated), 32'd0);
        chk("midrst.empty", 32'(gas_tank_empty), 32'd0);
        #1 rst_n = 1;
        tick(); tick();
        odo_pulse = 0;
        chk("midrst.idle_dist", 32'(trip_dist), 32'd0);
        chk("midrst.idle_arr",  32'(arrived),   32'd0);

        // Simultaneous strobes on all three paths.
        temp_valid = 1; temp_data = 8'd95;
        tick(); tick();
        trip_start = 1; dest_dist = 16'd7; odo_pulse = 1;
        fuel_valid = 1; fuel_level = 8'd3;
        tick();
        idle_inputs();
        chk("simul.dist",  32'(trip_dist),      32'd0);
        chk("simul.over",  32'(cpu_overheated), 32'd1);
        chk("simul.empty", 32'(gas_tank_empty), 32'd1);
        chk_model("simul");

        // Randomized run against the reference model.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            temp_valid = 1'($urandom_range(0, 1));
            temp_data  = 8'(70 + $urandom_range(0, 30));
            fuel_valid = ($urandom_range(0, 3) == 0);
            fuel_level = 8'($urandom_range(0, 20));
            trip_start = ($urandom_range(0, 39) == 0);
            dest_dist  = 16'($urandom_range(0, 20));
            odo_pulse  = 1'($urandom_range(0, 1));
            tick();
            chk_model($sformatf("rand%0d", i));
        end
        idle_inputs();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sensor_status.md
SENSOR_STATUS -- requirements
Module: sensor_status

Interface
REQ-001 Parameter: HOT_TH, default 8'd90, overheat entry threshold (temperature >= HOT_TH counts as hot).
REQ-002 Parameter: COOL_TH, default 8'd80, overheat exit threshold (temperature < COOL_TH counts as cool); COOL_TH < HOT_TH SHALL hold.
REQ-003 Parameter: FILT_N, default 3, consecutive qualifying samples required to change thermal state (range 1..15).
REQ-004 Parameter: FUEL_TH, default 8'd10, fuel level at or below which the tank counts as empty.
REQ-005 Ports, in order: clk input 1 (sole clock, rising edge); rst_n input 1 (asynchronous, active-low reset).
REQ-006 temp_valid input 1 (strobe: temp_data holds a new sample this cycle); temp_data input 8 (unsigned temperature).
REQ-007 fuel_valid input 1 (strobe: fuel_level holds a new sample this cycle); fuel_level input 8 (unsigned level).
REQ-008 trip_start input 1 (pulse: load dest_dist, start trip); dest_dist input 16 (target distance in odometer ticks); odo_pulse input 1 (one distance tick per cycle high).
REQ-009 cpu_overheated output 1; gas_tank_empty output 1; arrived output 1; trip_dist output 16 (ticks since trip_start). All outputs SHALL be registered.

Function
REQ-010 Thermal FSM states: COOL, WARMING, HOT, COOLING, with a 4-bit run counter; cpu_overheated SHALL be 1 in HOT and COOLING only.
REQ-011 COOL: on a valid sample >= HOT_TH, set counter to 1 and go to WARMING (go directly to HOT if FILT_N==1); other samples keep COOL.
REQ-012 WARMING: a valid sample >= HOT_TH increments the counter and enters HOT when the count reaches FILT_N; a valid sample < HOT_TH returns to COOL with counter 0.
REQ-013 HOT/COOLING: mirror of REQ-011/012 using valid samples < COOL_TH; reaching FILT_N returns to COOL; a valid sample >= COOL_TH in COOLING returns to HOT with counter 0.
REQ-014 Cycles with temp_valid low SHALL NOT change thermal state or counter.
REQ-015 gas_tank_empty SHALL update one cycle after a fuel_valid cycle to (fuel_level <= FUEL_TH) and SHALL hold otherwise.
REQ-016 Trip FSM states: IDLE, DRIVING, ARRIVED; arrived SHALL be 1 only in ARRIVED.
REQ-017 trip_start in any state: latch dest_dist, clear trip_dist to 0, enter DRIVING next cycle; odo_pulse in the same cycle is ignored.
REQ-018 DRIVING: each odo_pulse increments trip_dist by 1, saturating at 16'hFFFF.
REQ-019 DRIVING: when registered trip_dist >= latched target, enter ARRIVED next cycle; target 0 SHALL give arrived two cycles after trip_start.
REQ-020 ARRIVED: trip_dist keeps counting odo_pulse (saturating); the state is left only via trip_start or reset.
REQ-021 IDLE: odo_pulse ignored; trip_dist holds 0.
REQ-022 Thermal, fuel and trip paths SHALL be independent; simultaneous strobes SHALL all be processed in the same cycle.

Reset
REQ-023 rst_n low SHALL immediately force: thermal FSM COOL, counter 0, trip FSM IDLE, latched target 0, trip_dist 0, cpu_overheated 0, gas_tank_empty 0, arrived 0.
REQ-024 Reset asserted mid-trip or mid-filter SHALL discard all progress; the first rising edge after release SHALL process inputs normally.

Configuration
REQ-025 Macro SENSOR_STATUS_OVERHEAT_LATCH_EN defined: once HOT is entered, cpu_overheated SHALL stay 1 until rst_n, ignoring cool samples (HOT never exits).
REQ-026 Macro not defined: cpu_overheated follows REQ-010..013 with hysteresis exit.

Verification
REQ-027 FILT_N=3; temp samples 95,95,95 on consecutive valid cycles -> cpu_overheated rises one cycle after the third sample.
REQ-028 Samples 95,95,70,95,95 -> cpu_overheated stays 0 (run broken); then 85 x3 while HOT -> stays 1; then 79 x3 -> falls to 0 after the third (macro off), stays 1 (macro on).
REQ-029 fuel_valid with level 10 -> gas_tank_empty 1 next cycle; level 11 -> 0 next cycle; no strobe -> value held.
REQ-030 trip_start with dest_dist=5, then 5 odo_pulse -> trip_dist=5, arrived=1 one cycle later; trip_start with dest_dist=0 -> arrived=1 two cycles after trip_start.
REQ-031 Mid-trip at trip_dist=3, pulse rst_n low -> all outputs 0 immediately, trip FSM IDLE; odo_pulse after release -> trip_dist stays 0.
REQ-032 trip_start and odo_pulse in the same cycle, with temp_valid and fuel_valid also asserted -> trip_dist=0, and both the thermal and fuel paths update.
